// File: rtl/eeprom_i2c_slave.sv
`timescale 1ns/1ps
// eeprom_i2c_slave: I2C target modelling a 2 KB 24C16-style serial EEPROM (11-bit address)
// Ports: CLK system clock; RESET async active-high reset; SCL/SDA I2C bus (SDA open drain, drives 0 or z);
//        BUSY addressed transfer in progress; MEM_WE one-CLK write commit pulse; ADDR_PTR internal address pointer.
module eeprom_i2c_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter int         PAGE_BITS   = 4,
    parameter logic [3:0] DEV_ID      = 4'b1010
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SCL,
    inout  wire         SDA,
    output logic        BUSY,
    output logic        MEM_WE,
    output logic [10:0] ADDR_PTR
);
    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_d, r_sda_d, r_sda_oe, r_ack, r_rw, r_busy, r_mem_we;
    logic [2:0]             r_hi;
    logic [3:0]             r_cnt;
    logic [7:0]             r_shift;
    logic [10:0]            r_ptr;
    logic [7:0]             r_mem [2048];
    logic                   w_scl, w_sda, w_rise, w_fall, w_start, w_stop, w_wr;
    logic [7:0]             w_byte;
    logic [10:0]            w_ptr_inc, w_ptr_page;

    assign SDA      = r_sda_oe ? 1'b0 : 1'bz;
    assign BUSY     = r_busy;
    assign MEM_WE   = r_mem_we;
    assign ADDR_PTR = r_ptr;

    assign w_scl   = r_scl_sync[SYNC_STAGES-1];
    assign w_sda   = r_sda_sync[SYNC_STAGES-1];
    assign w_rise  = w_scl & ~r_scl_d;
    assign w_fall  = ~w_scl & r_scl_d;
    // SCL must be high on both samples so data edges while SCL is low are never decoded
    assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte  = {r_shift[6:0], w_sda};

    assign w_ptr_inc  = r_ptr + 11'd1;
    // page write: only the low PAGE_BITS roll over
    assign w_ptr_page = {r_ptr[10:PAGE_BITS], r_ptr[PAGE_BITS-1:0] + PAGE_BITS'(1)};
    assign w_wr       = (r_state == WR_ACK) && w_fall && !r_ack && !w_start && !w_stop;

    always_ff @(posedge CLK) begin
        if (w_wr)
            r_mem[r_ptr] <= r_shift;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_shift    <= 8'd0;
            r_sda_oe   <= 1'b0;
            r_ack      <= 1'b0;
            r_rw       <= 1'b0;
            r_hi       <= 3'd0;
            r_busy     <= 1'b0;
            r_mem_we   <= 1'b0;
            r_ptr      <= 11'd0;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], SCL};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], SDA};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
            r_mem_we   <= 1'b0;
            if (w_start) begin
                r_state  <= DEV_ADDR;
                r_cnt    <= 4'd0;
                r_sda_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= IDLE;
                r_cnt    <= 4'd0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    DEV_ADDR: if (w_rise) begin
                        r_shift <= w_byte;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            r_cnt <= 4'd0;
                            if (w_byte[7:4] != DEV_ID) begin
                                r_state <= IGNORE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_hi    <= w_byte[3:1];
                                r_rw    <= w_byte[0];
                                r_ack   <= 1'b0;
                                r_state <= DEV_ACK;
                            end
                        end
                    end
                    // first fall drives ACK (and prefetches the read byte), second fall ends it
                    DEV_ACK: if (w_fall) begin
                        if (!r_ack) begin
                            r_sda_oe <= 1'b1;
                            r_ack    <= 1'b1;
                            r_busy   <= 1'b1;
                            r_shift  <= r_mem[r_ptr];
                        end else if (r_rw) begin
                            r_sda_oe <= ~r_shift[7];
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_cnt    <= 4'd1;
                            r_state  <= RD_DATA;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_state  <= WORD_ADDR;
                        end
                    end
                    WORD_ADDR: if (w_rise) begin
                        r_shift <= w_byte;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            r_cnt   <= 4'd0;
                            r_ptr   <= {r_hi, w_byte};
                            r_ack   <= 1'b0;
                            r_state <= WADDR_ACK;
                        end
                    end
                    WADDR_ACK: if (w_fall) begin
                        r_sda_oe <= ~r_ack;
                        r_ack    <= 1'b1;
                        r_state  <= r_ack ? WR_DATA : WADDR_ACK;
                    end
                    WR_DATA: if (w_rise) begin
                        r_shift <= w_byte;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            r_cnt   <= 4'd0;
                            r_ack   <= 1'b0;
                            r_state <= WR_ACK;
                        end
                    end
                    // commit on the fall that starts the ACK; the memory write uses the same condition
                    WR_ACK: if (w_fall) begin
                        if (!r_ack) begin
                            r_sda_oe <= 1'b1;
                            r_ack    <= 1'b1;
                            r_mem_we <= 1'b1;
                            r_ptr    <= w_ptr_page;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_state  <= WR_DATA;
                        end
                    end
                    RD_DATA: if (w_fall) begin
                        if (r_cnt == 4'd8) begin
                            r_sda_oe <= 1'b0;
                            r_cnt    <= 4'd0;
                            r_state  <= RD_ACK;
                        end else begin
                            r_sda_oe <= ~r_shift[7];
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_cnt    <= r_cnt + 4'd1;
                        end
                    end
                    // pointer advances past every byte sent; only an ACK fetches the next one
                    RD_ACK: if (w_rise) begin
                        r_ptr <= w_ptr_inc;
                        if (!w_sda) begin
                            r_shift <= r_mem[w_ptr_inc];
                            r_state <= RD_DATA;
                        end else begin
                            r_state <= IGNORE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_eeprom_i2c_slave.sv
`timescale 1ns/1ps
// tb_eeprom_i2c_slave: bus-level master with scoreboarded write-commit and read-data monitors
module tb_eeprom_i2c_slave;
    localparam int PG = 16;
    logic        clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0;
    wire         sda;
    logic        busy, mem_we;
    logic [10:0] addr_ptr;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    eeprom_i2c_slave dut (
        .CLK(clk), .RESET(rst), .SCL(scl), .SDA(sda),
        .BUSY(busy), .MEM_WE(mem_we), .ADDR_PTR(addr_ptr)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_fail = 0;
    logic [7:0] mem_m [2048];
    bit         vld [2048];
    int         ptr_m = 0;
    int         q_we[$], q_rd[$];
    logic [7:0] wbuf [16];
    bit         rd_win = 1'b0;
    int         mon_n = 0, mon_e;
    logic [7:0] mon_sh = 8'd0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (mem_we) begin
        if (q_we.size() == 0) chk("unexpected MEM_WE", 1, 0);
        else chk("ptr at MEM_WE", addr_ptr, q_we.pop_front());
    end

    always @(posedge scl) if (rd_win) begin
        mon_sh = {mon_sh[6:0], sda};
        mon_n++;
        if (mon_n == 8) begin
            mon_n = 0;
            if (q_rd.size() == 0) chk("unexpected read byte", 1, 0);
            else begin
                mon_e = q_rd.pop_front();
                if (mon_e >= 0) chk("read byte", mon_sh, mon_e);
            end
        end
    end

    task automatic hold();
        repeat (5) @(negedge clk);
    endtask

    task automatic bit_io(input logic b, output logic r);
        m_low = ~b; hold();
        scl = 1'b1; hold();
        r = sda; hold();
        scl = 1'b0; hold();
    endtask

    task automatic start();
        m_low = 1'b0; scl = 1'b1; hold();
        m_low = 1'b1; hold();
        scl = 1'b0; hold();
    endtask

    task automatic stop();
        m_low = 1'b1; hold();
        scl = 1'b1; hold();
        m_low = 1'b0; hold(); hold();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(d[i], r);
        bit_io(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack);
        logic r;
        rd_win = 1'b1;
        for (int i = 0; i < 8; i++) bit_io(1'b1, r);
        rd_win = 1'b0;
        bit_io(nack, r);
    endtask

    task automatic set_ptr(input int a);
        logic ack;
        start();
        send_byte(8'(8'hA0 | ((a / 256) * 2)), ack);
        chk("ctrl W ack", ack, 0);
        send_byte(8'(a % 256), ack);
        chk("word addr ack", ack, 0);
        ptr_m = a;
    endtask

    task automatic write_txn(input int a, input int n);
        logic ack;
        set_ptr(a);
        for (int k = 0; k < n; k++) begin
            mem_m[ptr_m] = wbuf[k];
            vld[ptr_m] = 1'b1;
            ptr_m = (ptr_m / PG) * PG + (ptr_m % PG + 1) % PG;
            q_we.push_back(ptr_m);
            send_byte(wbuf[k], ack);
            chk("data ack", ack, 0);
        end
        stop();
        chk("busy after write stop", busy, 0);
    endtask

    task automatic read_txn(input int n);
        logic ack;
        start();
        send_byte(8'(8'hA1 | ((ptr_m / 256) * 2)), ack);
        chk("ctrl R ack", ack, 0);
        chk("busy after ctrl ack", busy, 1);
        for (int k = 0; k < n; k++) begin
            q_rd.push_back(vld[ptr_m] ? int'(mem_m[ptr_m]) : -1);
            ptr_m = (ptr_m + 1) % 2048;
            read_byte(k == n - 1);
            chk("ptr after read", addr_ptr, ptr_m);
        end
        chk("sda released after nack", sda, 1);
        stop();
        chk("busy after read stop", busy, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic ack, r;
        int a, n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold();
        chk("reset busy", busy, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset addr_ptr", addr_ptr, 0);
        chk("reset sda", sda, 1);

        wbuf[0] = 8'h5C;
        write_txn('h135, 1);
        chk("ptr after byte write", addr_ptr, 'h136);
        set_ptr('h135);
        read_txn(1);
        chk("ptr after random read", addr_ptr, 'h136);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        write_txn('h00E, 3);
        chk("ptr after page wrap", addr_ptr, 'h001);
        set_ptr('h00E);
        read_txn(2);
        set_ptr('h000);
        read_txn(1);

        wbuf[0] = 8'h9E;
        write_txn('h7FF, 1);
        set_ptr('h7FF);
        read_txn(2);

        start();
        send_byte(8'hB0, ack);
        chk("wrong device no ack", ack, 1);
        chk("wrong device busy", busy, 0);
        send_byte(8'h35, ack);
        chk("ignored byte no ack", ack, 1);
        stop();
        chk("ptr after wrong device", addr_ptr, ptr_m);

        wbuf[0] = 8'hA5;
        write_txn('h040, 1);
        set_ptr('h040);
        for (int i = 0; i < 4; i++) bit_io(i[0], r);
        stop();
        chk("busy after abort", busy, 0);
        chk("ptr after abort", addr_ptr, 'h040);
        start();
        send_byte(8'hA1, ack);
        chk("ctrl R ack before reset", ack, 0);
        for (int i = 0; i < 3; i++) bit_io(1'b1, r);
        rst = 1'b1;
        @(negedge clk);
        chk("sda in reset", sda, 1);
        chk("busy in reset", busy, 0);
        chk("ptr in reset", addr_ptr, 0);
        rst = 1'b0;
        m_low = 1'b0; scl = 1'b1; hold(); hold();
        ptr_m = 0;
        set_ptr('h040);
        read_txn(1);

        for (int it = 0; it < 5; it++) begin
            a = int'($urandom_range(0, 2047));
            n = int'($urandom_range(1, 8));
            for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
            write_txn(a, n);
            set_ptr(a);
            read_txn(n);
        end

        hold();
        chk("write queue drained", q_we.size(), 0);
        chk("read queue drained", q_rd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
